// File: rtl/ec_scalar_seq_if.sv
// ----------------------------------------------------------------------------
// ec_scalar_seq_if
// Bundle of the request, ALU handshake and status signals of ec_scalar_seq.
//
//   start                 requester -> sequencer  begin a point multiplication
//   scalar[SCALAR_W]      requester -> sequencer  scalar k, sampled on accept
//   alu_in_valid          sequencer -> ALU        one-cycle operation launch
//   alu_in_state[2]       sequencer -> ALU        opcode (PRE/DBL/DIV-INV/DIV-MUL)
//   alu_consecutive_flag  sequencer -> ALU        scalar bit or exponent bit
//   alu_out_ready         ALU -> sequencer        last cycle of running operation
//   busy                  sequencer -> requester  sequence in progress
//   done                  sequencer -> requester  one-cycle completion pulse
//   bit_idx[8]            sequencer -> requester  bit currently processed
//
// Modports: slave = sequencer side, master = requester/ALU side.
// ----------------------------------------------------------------------------
interface ec_scalar_seq_if #(
  parameter int SCALAR_W = 255
);
  logic                start;
  logic [SCALAR_W-1:0] scalar;
  logic                alu_in_valid;
  logic [1:0]          alu_in_state;
  logic                alu_consecutive_flag;
  logic                alu_out_ready;
  logic                busy;
  logic                done;
  logic [7:0]          bit_idx;

  modport slave (
    input  start,
    input  scalar,
    input  alu_out_ready,
    output alu_in_valid,
    output alu_in_state,
    output alu_consecutive_flag,
    output busy,
    output done,
    output bit_idx
  );

  modport master (
    output start,
    output scalar,
    output alu_out_ready,
    input  alu_in_valid,
    input  alu_in_state,
    input  alu_consecutive_flag,
    input  busy,
    input  done,
    input  bit_idx
  );
endinterface

// File: rtl/ec_scalar_seq.sv
// ----------------------------------------------------------------------------
// ec_scalar_seq
// Operation sequencer for an elliptic-curve point multiplication. It walks
// the scalar MSB first issuing one DOUBLE per bit (flagging when an ADD must
// follow), then walks the inversion exponent MSB first issuing one DIV-INV
// per bit, framed by a PRE-CAL at the start and a DIV-MUL at the end.
// Each operation is launched with a single-cycle alu_in_valid (ISSUE phase)
// and then waits for alu_out_ready (WAIT phase) before the next launch.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   bus   ec_scalar_seq_if.slave (start, scalar, alu_* handshake,
//         busy, done, bit_idx)
//
// Parameters:
//   SCALAR_W  scalar width
//   INV_W     inversion exponent width
//   INV_EXP   inversion exponent, consumed MSB first (default 2^255-21)
//
// Build option:
//   SKIP_LEADING_ZERO_EN  when defined, DOUBLE operations for scalar bits
//                         above the most significant set bit are skipped and
//                         a zero scalar goes straight from PRE-CAL to DIV-INV.
//
// All outputs are registered; they are computed from the next state so they
// line up with the state register.
// ----------------------------------------------------------------------------
module ec_scalar_seq #(
  parameter int              SCALAR_W = 255,
  parameter int              INV_W    = 255,
  parameter logic [INV_W-1:0] INV_EXP = {{(INV_W-5){1'b1}}, 5'b01011}
) (
  input  logic               clk,
  input  logic               rst,
  ec_scalar_seq_if.slave     bus
);

  // Sequencer states: one ISSUE and one WAIT state per operation type.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE_ISS  = 4'd1;
  localparam logic [3:0] S_PRE_WAIT = 4'd2;
  localparam logic [3:0] S_DBL_ISS  = 4'd3;
  localparam logic [3:0] S_DBL_WAIT = 4'd4;
  localparam logic [3:0] S_INV_ISS  = 4'd5;
  localparam logic [3:0] S_INV_WAIT = 4'd6;
  localparam logic [3:0] S_MUL_ISS  = 4'd7;
  localparam logic [3:0] S_MUL_WAIT = 4'd8;
  localparam logic [3:0] S_FIN      = 4'd9;

  // ALU opcodes.
  localparam logic [1:0] OP_PRE = 2'd0;
  localparam logic [1:0] OP_DBL = 2'd1;
  localparam logic [1:0] OP_INV = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  localparam logic [7:0] SCALAR_TOP = 8'(SCALAR_W - 1);
  localparam logic [7:0] INV_TOP    = 8'(INV_W - 1);

  logic [3:0]          state_q, state_d;
  logic [SCALAR_W-1:0] scalar_q, scalar_d;
  logic [7:0]          bit_idx_q, bit_idx_d;
  logic                valid_q, valid_d;
  logic [1:0]          op_q, op_d;
  logic                flag_q, flag_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef SKIP_LEADING_ZERO_EN
  // Index of the highest set bit of k; 0 when k is zero.
  function automatic logic [7:0] msb_index(input logic [SCALAR_W-1:0] k);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 0; i < SCALAR_W; i++) begin
      if (k[i]) begin
        idx = 8'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  // Next-state, scalar latch and bit index bookkeeping.
  always_comb begin
    state_d   = state_q;
    scalar_d  = scalar_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          scalar_d = bus.scalar;
`ifdef SKIP_LEADING_ZERO_EN
          bit_idx_d = msb_index(bus.scalar);
`else
          bit_idx_d = SCALAR_TOP;
`endif
          state_d = S_PRE_ISS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE_ISS: begin
        state_d = S_PRE_WAIT;
      end
      S_PRE_WAIT: begin
        if (bus.alu_out_ready) begin
`ifdef SKIP_LEADING_ZERO_EN
          // A zero scalar has no set bit, so there is nothing to double.
          if (scalar_q == {SCALAR_W{1'b0}}) begin
            state_d   = S_INV_ISS;
            bit_idx_d = INV_TOP;
          end else begin
            state_d = S_DBL_ISS;
          end
`else
          state_d = S_DBL_ISS;
`endif
        end else begin
          state_d = S_PRE_WAIT;
        end
      end
      S_DBL_ISS: begin
        state_d = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        if (bus.alu_out_ready) begin
          if (bit_idx_q == 8'd0) begin
            state_d   = S_INV_ISS;
            bit_idx_d = INV_TOP;
          end else begin
            state_d   = S_DBL_ISS;
            bit_idx_d = bit_idx_q - 8'd1;
          end
        end else begin
          state_d = S_DBL_WAIT;
        end
      end
      S_INV_ISS: begin
        state_d = S_INV_WAIT;
      end
      S_INV_WAIT: begin
        if (bus.alu_out_ready) begin
          if (bit_idx_q == 8'd0) begin
            state_d = S_MUL_ISS;
          end else begin
            state_d   = S_INV_ISS;
            bit_idx_d = bit_idx_q - 8'd1;
          end
        end else begin
          state_d = S_INV_WAIT;
        end
      end
      S_MUL_ISS: begin
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (bus.alu_out_ready) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MUL_WAIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered; opcode and flag depend only
  // on the state and bit index, so they stay stable through the WAIT phase.
  always_comb begin
    valid_d = 1'b0;
    op_d    = OP_PRE;
    flag_d  = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_d)
      S_PRE_ISS, S_PRE_WAIT: begin
        valid_d = (state_d == S_PRE_ISS);
        op_d    = OP_PRE;
        flag_d  = 1'b0;
      end
      S_DBL_ISS, S_DBL_WAIT: begin
        valid_d = (state_d == S_DBL_ISS);
        op_d    = OP_DBL;
        flag_d  = scalar_q[bit_idx_d];
      end
      S_INV_ISS, S_INV_WAIT: begin
        valid_d = (state_d == S_INV_ISS);
        op_d    = OP_INV;
        flag_d  = INV_EXP[bit_idx_d];
      end
      S_MUL_ISS, S_MUL_WAIT: begin
        valid_d = (state_d == S_MUL_ISS);
        op_d    = OP_MUL;
        flag_d  = 1'b0;
      end
      S_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, scalar, index and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      scalar_q  <= {SCALAR_W{1'b0}};
      bit_idx_q <= 8'd0;
      valid_q   <= 1'b0;
      op_q      <= OP_PRE;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scalar_q  <= scalar_d;
      bit_idx_q <= bit_idx_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.alu_in_valid         = valid_q;
  assign bus.alu_in_state         = op_q;
  assign bus.alu_consecutive_flag = flag_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.bit_idx              = bit_idx_q;

endmodule

// File: doc/ec_scalar_seq.md
EC_SCALAR_SEQ -- requirements
Module: ec_scalar_seq

Interface
REQ-001 Parameter SCALAR_W, default 255, width of the scalar in bits.
REQ-002 Parameter INV_W, default 255, width of the inversion exponent in bits.
REQ-003 Parameter INV_EXP, default 2^255-21 (q-2), the inversion exponent, consumed MSB first.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a point multiplication.
REQ-007 scalar  input  SCALAR_W  scalar k, sampled only on an accepted start.
REQ-008 alu_in_valid  output  1  one-cycle operation launch to the ALU.
REQ-009 alu_in_state  output  2  ALU opcode: 0 PRE-CAL, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL.
REQ-010 alu_consecutive_flag  output  1  for DOUBLE, the current scalar bit (add follows); for DIV-INV, the current exponent bit.
REQ-011 alu_out_ready  input  1  ALU last-cycle indication for the running operation.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse when the sequence completes.
REQ-014 bit_idx  output  8  index of the scalar or exponent bit being processed.

Function
REQ-015 States: IDLE, PRE, DBL, INV, MUL, FIN; each operation state has an ISSUE phase and a WAIT phase.
REQ-016 start is accepted only in IDLE; start in any other state is ignored, with no effect on outputs.
REQ-017 On accept: latch scalar, set bit_idx=SCALAR_W-1, busy=1, enter PRE/ISSUE on the next edge.
REQ-018 In ISSUE: alu_in_valid=1 for exactly one cycle with the state's opcode, then move to WAIT.
REQ-019 In WAIT: alu_in_valid=0; on alu_out_ready=1, advance on that edge; the next ISSUE occurs in the following cycle, when the ALU is back in IDLE.
REQ-020 alu_in_state and alu_consecutive_flag are held stable from ISSUE through the cycle alu_out_ready is seen.
REQ-021 PRE: one PRE-CAL op (flag=0), then go to DBL.
REQ-022 DBL: one DOUBLE op per scalar bit, MSB first, flag=scalar[bit_idx].
REQ-023 DBL, after each DOUBLE: if bit_idx=0, go to INV with bit_idx=INV_W-1; otherwise decrement bit_idx.
REQ-024 INV: one DIV-INV op per exponent bit, MSB first, flag=INV_EXP[bit_idx].
REQ-025 INV, after each DIV-INV: if bit_idx=0, go to MUL; otherwise decrement bit_idx.
REQ-026 MUL: one DIV-MUL op (flag=0), then FIN.
REQ-027 FIN: done=1 and busy=0 for one cycle, then IDLE.
REQ-028 alu_out_ready seen outside WAIT is ignored.
REQ-029 Timing with the team ALU (PRE/INV/MUL ready 4 cycles after launch; DOUBLE ready after 10, or 20 with add): PRE costs 5 cycles, DOUBLE 11, DOUBLE+ADD 21, DIV-INV 5, DIV-MUL 5.
REQ-030 bit_idx holds its value in IDLE and in FIN.

Reset
REQ-031 rst=1 forces, asynchronously: state IDLE, alu_in_valid=0, alu_in_state=0, alu_consecutive_flag=0, busy=0, done=0, bit_idx=0, latched scalar=0.
REQ-032 Reset mid-sequence abandons the operation; no done is produced; the first start after reset release is accepted normally.

Configuration
REQ-033 Macro SKIP_LEADING_ZERO_EN, when defined, makes the block skip DOUBLE ops for scalar bits above the most significant set bit.
REQ-034 With SKIP_LEADING_ZERO_EN, on accept bit_idx starts at the index of the highest set bit.
REQ-035 With SKIP_LEADING_ZERO_EN, a scalar of 0 goes from PRE directly to INV.
REQ-036 Without SKIP_LEADING_ZERO_EN, all SCALAR_W DOUBLE ops are always issued.

Verification
REQ-037 Scalar all ones, no macro -> 1 PRE, 255 DOUBLE with flag=1, 255 DIV-INV, 1 DIV-MUL; done at cycle 6641 after start, ±0.
REQ-038 Scalar=1, no macro -> 254 DOUBLE with flag=0, then 1 with flag=1; DIV-INV flags 1,...,1,0,1,0,1,1 (low 5 bits 01011).
REQ-039 Scalar=5 with SKIP_LEADING_ZERO_EN -> exactly 3 DOUBLE ops with flags 1,0,1; scalar=0 -> 0 DOUBLE ops.
REQ-040 start pulsed during WAIT of DOUBLE -> ignored; op count and the latched scalar are unchanged.
REQ-041 rst asserted mid-INV -> all outputs reach their reset values within the same cycle; a new start yields a complete sequence with one done.
REQ-042 ALU model delaying out_ready by a random 4-40 cycles -> alu_in_valid never asserts while an op is outstanding; the op sequence is unchanged.
